// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit saturating counter states
// and the counter values used at reset and on allocation.
package bp_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WEAK_NT;
    localparam ctr_e CTR_ALLOC = WEAK_T;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import bp_pkg::*;
(
    input  ctr_e state_i,
    input  logic taken_i,
    output ctr_e next_o
);

    always_comb begin
        next_o = state_i;
        case (state_i)
            STRONG_NT: next_o = taken_i ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   next_o = taken_i ? WEAK_T   : STRONG_NT;
            WEAK_T:    next_o = taken_i ? STRONG_T : WEAK_NT;
            STRONG_T:  next_o = taken_i ? STRONG_T : WEAK_T;
            default:   next_o = state_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters and
// saturating branch/mispredict performance counters.
module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_next_pc,
    input  logic              update_en,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [ADDR_W-1:0] update_target,
    input  logic              update_mispred,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    ctr_e              ctr_q    [ENTRIES];

    logic [CNT_W-1:0]  branchCnt_q, branchCnt_d;
    logic [CNT_W-1:0]  mispredCnt_q, mispredCnt_d;

    logic [IDX_W-1:0]  lookupIdx, updIdx;
    logic [TAG_W-1:0]  lookupTag, updTag;
    logic              updHit;
    ctr_e              ctrNext_d;
    logic              unusedPcBits;

    // PC bits [1:0] never take part in indexing or tag compare.
    assign unusedPcBits = ^update_pc[1:0];

    assign lookupIdx = lookup_pc[IDX_W+1:2];
    assign lookupTag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign updIdx    = update_pc[IDX_W+1:2];
    assign updTag    = update_pc[ADDR_W-1:IDX_W+2];

    // Lookup reads only registered state, so a same-cycle update is not visible.
    assign pred_hit     = valid_q[lookupIdx] && (tag_q[lookupIdx] == lookupTag);
    assign pred_taken   = pred_hit && ctr_q[lookupIdx][1];
    assign pred_next_pc = pred_taken ? target_q[lookupIdx] : lookup_pc + ADDR_W'(4);

    assign updHit = valid_q[updIdx] && (tag_q[updIdx] == updTag);

    sat_counter2 u_sat_counter2 (
        .state_i (ctr_q[updIdx]),
        .taken_i (update_taken),
        .next_o  (ctrNext_d)
    );

    always_comb begin
        branchCnt_d  = branchCnt_q;
        mispredCnt_d = mispredCnt_q;
        if (update_en) begin
            if (branchCnt_q != '1) begin
                branchCnt_d = branchCnt_q + CNT_W'(1);
            end
            if (update_mispred && (mispredCnt_q != '1)) begin
                mispredCnt_d = mispredCnt_q + CNT_W'(1);
            end
        end
    end

    // Whole-table reset in one cycle; tags and targets are left as don't-care.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RESET;
            end
            branchCnt_q  <= '0;
            mispredCnt_q <= '0;
        end else begin
            if (update_en) begin
                if (updHit) begin
                    ctr_q[updIdx] <= ctrNext_d;
                    if (update_taken) begin
                        target_q[updIdx] <= update_target;
                    end
                end else if (update_taken) begin
                    valid_q[updIdx]  <= 1'b1;
                    tag_q[updIdx]    <= updTag;
                    target_q[updIdx] <= update_target;
                    ctr_q[updIdx]    <= CTR_ALLOC;
                end
            end
            branchCnt_q  <= branchCnt_d;
            mispredCnt_q <= mispredCnt_d;
        end
    end

    assign branch_cnt  = branchCnt_q;
    assign mispred_cnt = mispredCnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench: a default-width instance and a CNT_W=2 instance share stimulus.
module tb_branch_predictor_btb;

    logic        clk;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispred;

    logic        predHit, predTaken;
    logic [31:0] predNextPc;
    logic [15:0] branchCnt16, mispredCnt16;
    logic        predHit2, predTaken2;
    logic [31:0] predNextPc2;
    logic [1:0]  branchCnt2, mispredCnt2;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] npc;
        logic [15:0] bc16;
        logic [15:0] mc16;
        logic [1:0]  bc2;
        logic [1:0]  mc2;
    } exp_t;

    exp_t expQ[$];
    int   vectors;
    int   miscompares;
    bit   stimDone;

    branch_predictor_btb #(.ADDR_W(32), .ENTRIES(16), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_pc      (lookup_pc),
        .pred_hit       (predHit),
        .pred_taken     (predTaken),
        .pred_next_pc   (predNextPc),
        .update_en      (update_en),
        .update_pc      (update_pc),
        .update_taken   (update_taken),
        .update_target  (update_target),
        .update_mispred (update_mispred),
        .branch_cnt     (branchCnt16),
        .mispred_cnt    (mispredCnt16)
    );

    branch_predictor_btb #(.ADDR_W(32), .ENTRIES(16), .CNT_W(2)) dutSmall (
        .clk            (clk),
        .reset          (reset),
        .lookup_pc      (lookup_pc),
        .pred_hit       (predHit2),
        .pred_taken     (predTaken2),
        .pred_next_pc   (predNextPc2),
        .update_en      (update_en),
        .update_pc      (update_pc),
        .update_taken   (update_taken),
        .update_target  (update_target),
        .update_mispred (update_mispred),
        .branch_cnt     (branchCnt2),
        .mispred_cnt    (mispredCnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string vec, input string field,
                               input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s.%s got %0h expected %0h", vec, field, got, want);
        end
    endtask

    // Drives one cycle of inputs just after the edge and queues what the
    // outputs must show before the next edge commits anything.
    task automatic applyStimulus(input string name, input logic rst, input logic [31:0] lpc,
                                 input logic uen, input logic [31:0] upc, input logic utk,
                                 input logic [31:0] utgt, input logic umis,
                                 input logic eHit, input logic eTaken, input logic [31:0] eNpc,
                                 input logic [15:0] eBc16, input logic [15:0] eMc16,
                                 input logic [1:0] eBc2, input logic [1:0] eMc2);
        exp_t e;
        @(posedge clk);
        #1;
        reset          = rst;
        lookup_pc      = lpc;
        update_en      = uen;
        update_pc      = upc;
        update_taken   = utk;
        update_target  = utgt;
        update_mispred = umis;
        e.name  = name;
        e.hit   = eHit;
        e.taken = eTaken;
        e.npc   = eNpc;
        e.bc16  = eBc16;
        e.mc16  = eMc16;
        e.bc2   = eBc2;
        e.mc2   = eMc2;
        expQ.push_back(e);
    endtask

    // Monitor: the predictor answers combinationally, so each queued vector
    // is compared at the falling edge of the cycle it was driven in.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            vectors++;
            checkOutput(e.name, "hit",   {31'd0, predHit},      {31'd0, e.hit});
            checkOutput(e.name, "taken", {31'd0, predTaken},    {31'd0, e.taken});
            checkOutput(e.name, "npc",   predNextPc,            e.npc);
            checkOutput(e.name, "bc16",  {16'd0, branchCnt16},  {16'd0, e.bc16});
            checkOutput(e.name, "mc16",  {16'd0, mispredCnt16}, {16'd0, e.mc16});
            checkOutput(e.name, "bc2",   {30'd0, branchCnt2},   {30'd0, e.bc2});
            checkOutput(e.name, "mc2",   {30'd0, mispredCnt2},  {30'd0, e.mc2});
            checkOutput(e.name, "hit2",  {31'd0, predHit2},     {31'd0, e.hit});
        end
    end

    initial begin
        vectors        = 0;
        miscompares    = 0;
        stimDone       = 1'b0;
        reset          = 1'b1;
        lookup_pc      = 32'h40;
        update_en      = 1'b0;
        update_pc      = '0;
        update_taken   = 1'b0;
        update_target  = '0;
        update_mispred = 1'b0;

        //              name            rst lookup        uen upc           tk  target        mis  hit tk  npc           bc16 mc16 bc2 mc2
        applyStimulus("reset_lookup",   0, 32'h40,       0, 32'h0,        0, 32'h0,        0,   0,  0, 32'h44,       0,   0,   0,  0);
        applyStimulus("alloc_same_cyc", 0, 32'h40,       1, 32'h40,       1, 32'h80,       1,   0,  0, 32'h44,       0,   0,   0,  0);
        applyStimulus("hit_after_alloc",0, 32'h40,       0, 32'h0,        0, 32'h0,        0,   1,  1, 32'h80,       1,   1,   1,  1);
        applyStimulus("alias_tag",      0, 32'h440,      0, 32'h0,        0, 32'h0,        0,   0,  0, 32'h444,      1,   1,   1,  1);
        applyStimulus("nt_upd1",        0, 32'h40,       1, 32'h40,       0, 32'h999,      1,   1,  1, 32'h80,       1,   1,   1,  1);
        applyStimulus("nt_upd2",        0, 32'h40,       1, 32'h40,       0, 32'h999,      1,   1,  0, 32'h44,       2,   2,   2,  2);
        applyStimulus("nt_upd3",        0, 32'h40,       1, 32'h40,       0, 32'h999,      1,   1,  0, 32'h44,       3,   3,   3,  3);
        applyStimulus("tk_from_00",     0, 32'h40,       1, 32'h40,       1, 32'h100,      1,   1,  0, 32'h44,       4,   4,   3,  3);
        applyStimulus("ctr_01_nt",      0, 32'h40,       0, 32'h0,        0, 32'h0,        0,   1,  0, 32'h44,       5,   5,   3,  3);
        applyStimulus("tk_no_mispred",  0, 32'h40,       1, 32'h40,       1, 32'h100,      0,   1,  0, 32'h44,       5,   5,   3,  3);
        applyStimulus("target_updated", 0, 32'h40,       0, 32'h0,        0, 32'h0,        0,   1,  1, 32'h100,      6,   5,   3,  3);
        applyStimulus("miss_nt_upd",    0, 32'h40,       1, 32'h80,       0, 32'h777,      0,   1,  1, 32'h100,      6,   5,   3,  3);
        applyStimulus("miss_nt_noalloc",0, 32'h80,       0, 32'h0,        0, 32'h0,        0,   0,  0, 32'h84,       7,   5,   3,  3);
        applyStimulus("low_bits_ignored",0,32'h43,       0, 32'h0,        0, 32'h0,        0,   1,  1, 32'h100,      7,   5,   3,  3);
        applyStimulus("reset_with_upd", 1, 32'h40,       1, 32'h200,      1, 32'h300,      1,   1,  1, 32'h100,      7,   5,   3,  3);
        applyStimulus("post_reset",     0, 32'h40,       0, 32'h0,        0, 32'h0,        0,   0,  0, 32'h44,       0,   0,   0,  0);
        applyStimulus("reset_no_alloc", 0, 32'h200,      0, 32'h0,        0, 32'h0,        0,   0,  0, 32'h204,      0,   0,   0,  0);
        applyStimulus("wrap_alloc",     0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 32'h8,        0,   0,  0, 32'h0,        0,   0,   0,  0);
        applyStimulus("wrap_hit",       0, 32'hFFFFFFFC, 0, 32'h0,        0, 32'h0,        0,   1,  1, 32'h8,        1,   0,   1,  0);
        applyStimulus("tk_to_11",       0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 32'hC,        0,   1,  1, 32'h8,        1,   0,   1,  0);
        applyStimulus("tk_sat_11",      0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 32'hC,        0,   1,  1, 32'hC,        2,   0,   2,  0);
        applyStimulus("nt_from_11",     0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0,        0,   1,  1, 32'hC,        3,   0,   3,  0);
        applyStimulus("still_taken",    0, 32'hFFFFFFFC, 0, 32'h0,        0, 32'h0,        0,   1,  1, 32'hC,        4,   0,   3,  0);

        @(posedge clk);
        #1;
        update_en = 1'b0;
        stimDone  = 1'b1;
        for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
            @(posedge clk);
        end
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain got %0d pending expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_predictor_btb.md
BRANCH_PREDICTOR_BTB -- requirements
Module: branch_predictor_btb

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, PC width; ENTRIES, default 16, BTB depth, power of two, >=2; CNT_W, default 16, width of each performance counter.
REQ-002 Port clk, input, 1, rising-edge clock for all state.
REQ-003 Port reset, input, 1, synchronous active-high reset, sampled on posedge clk.
REQ-004 Port lookup_pc, input, ADDR_W, fetch-stage PC to predict.
REQ-005 Port pred_hit, output, 1, lookup_pc matches a valid entry.
REQ-006 Port pred_taken, output, 1, predict taken.
REQ-007 Port pred_next_pc, output, ADDR_W, predicted next fetch PC.
REQ-008 Port update_en, input, 1, a resolved branch is presented this cycle.
REQ-009 Port update_pc, input, ADDR_W, PC of the resolved branch.
REQ-010 Port update_taken, input, 1, actual branch outcome.
REQ-011 Port update_target, input, ADDR_W, actual branch target.
REQ-012 Port update_mispred, input, 1, the earlier prediction for this branch was wrong; only meaningful with update_en.
REQ-013 Port branch_cnt, output, CNT_W, number of accepted updates.
REQ-014 Port mispred_cnt, output, CNT_W, number of accepted updates with update_mispred=1.

Function
REQ-015 The index SHALL be pc[IDX_W+1:2] with IDX_W=log2(ENTRIES); the tag SHALL be pc[ADDR_W-1:IDX_W+2].
REQ-016 Each entry SHALL hold valid (1b), tag, target (ADDR_W), and a 2-bit counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-017 Lookup SHALL be combinational, with zero cycles from lookup_pc to outputs: pred_hit = valid & tag match; pred_taken = pred_hit & ctr[1]; pred_next_pc = pred_taken ? target : lookup_pc+4, modulo 2^ADDR_W.
REQ-018 Updates SHALL be committed only on posedge clk when update_en=1 and reset=0.
REQ-019 On an update hit with update_taken=1, the counter SHALL increment, saturating at 11, and target SHALL be overwritten with update_target.
REQ-020 On an update hit with update_taken=0, the counter SHALL decrement, saturating at 00; target SHALL be left unchanged.
REQ-021 On an update miss with update_taken=1, the entry SHALL be allocated, overwriting any previous occupant: valid=1, new tag, target=update_target, counter=10.
REQ-022 On an update miss with update_taken=0, no entry SHALL change.
REQ-023 Read-during-write: if a lookup and an update address the same index in the same cycle, the lookup SHALL return the pre-update state, with no bypass.
REQ-024 branch_cnt SHALL increment by 1 per accepted update; mispred_cnt SHALL increment when update_mispred=1 also holds; both SHALL saturate at all-ones and never wrap.
REQ-025 update_mispred SHALL NOT affect BTB state, only mispred_cnt.
REQ-026 The low 2 bits of PCs SHALL be ignored for indexing and tag compare.

Reset
REQ-027 While reset=1 at posedge clk, every entry SHALL be set to valid=0, counter=01, and branch_cnt=mispred_cnt=0; target and tag values are don't-care.
REQ-028 Reset SHALL take priority over a simultaneous update_en; that update is discarded.
REQ-029 After the reset cycle, pred_hit=0, pred_taken=0 and pred_next_pc=lookup_pc+4 for every lookup_pc.
REQ-030 Reset asserted mid-operation SHALL discard all learned state in the same single cycle.

Structure
REQ-031 Shared package bp_pkg SHALL hold the counter state enum (STRONG_NT, WEAK_NT, WEAK_T, STRONG_T), the constant CTR_RESET=WEAK_NT, and the constant CTR_ALLOC=WEAK_T.
REQ-032 Saturating 2-bit counter next-state logic SHALL live in one sub-module, sat_counter2 (inputs: state, taken; output: next state), instantiated once on the update path.
REQ-033 Entry storage SHALL be flop arrays, not inferred RAM macros, to allow single-cycle whole-table reset.

Verification
REQ-034 Reset, then lookup_pc=0x0000_0040 -> pred_hit=0, pred_taken=0, pred_next_pc=0x0000_0044.
REQ-035 Update pc=0x40, taken=1, target=0x80; next cycle lookup 0x40 -> hit=1, taken=1, next_pc=0x80; lookup 0x440 (same index, different tag) -> hit=0, next_pc=0x444.
REQ-036 Starting from ctr=10 at 0x40, apply three not-taken updates then one taken update -> counter goes 01, 00, 00, 01; pred_taken=0 after the last update.
REQ-037 Same-cycle lookup and update at 0x40 (first taken update) -> that cycle hit=0; the following cycle hit=1.
REQ-038 With CNT_W=2, apply 5 updates with update_mispred=1 -> branch_cnt=3 and mispred_cnt=3, saturated; assert reset together with update_en -> both counters 0 and no allocation.
